// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM.
// One grant per cycle; an owner keeps the port for at most BURST_LEN grants while the other waits.
module ram_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wen,
    output logic [DATA_W-1:0] ram_wdat,
    output logic              ram_ren,
    input  logic [DATA_W-1:0] ram_rdat
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    localparam logic       LAST_A  = 1'b0;
    localparam logic       LAST_B  = 1'b1;
    localparam logic [3:0] CNT_MAX = 4'(BURST_LEN);

    owner_e     owner_q, owner_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       last_q, last_d;
    logic       rd_pend_a_q, rd_pend_b_q;
    logic       sel_a, sel_b;
    logic       burst_left;

    assign burst_left = (burst_cnt_q < CNT_MAX);

    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        last_d      = last_q;
        sel_a       = 1'b0;
        sel_b       = 1'b0;
        case (owner_q)
            OWN_A: begin
                if (req_a && burst_left) begin
                    sel_a       = 1'b1;
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end else if (req_b) begin
                    sel_b       = 1'b1;
                    owner_d     = OWN_B;
                    burst_cnt_d = 4'd1;
                end else if (req_a) begin
                    sel_a       = 1'b1;
                    burst_cnt_d = 4'd1;
                end else begin
                    owner_d     = OWN_NONE;
                    burst_cnt_d = 4'd0;
                end
            end
            OWN_B: begin
                if (req_b && burst_left) begin
                    sel_b       = 1'b1;
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end else if (req_a) begin
                    sel_a       = 1'b1;
                    owner_d     = OWN_A;
                    burst_cnt_d = 4'd1;
                end else if (req_b) begin
                    sel_b       = 1'b1;
                    burst_cnt_d = 4'd1;
                end else begin
                    owner_d     = OWN_NONE;
                    burst_cnt_d = 4'd0;
                end
            end
            default: begin
                // Tie from idle goes to whoever was not granted last.
                if (req_a && (!req_b || last_q == LAST_B)) begin
                    sel_a       = 1'b1;
                    owner_d     = OWN_A;
                    burst_cnt_d = 4'd1;
                end else if (req_b) begin
                    sel_b       = 1'b1;
                    owner_d     = OWN_B;
                    burst_cnt_d = 4'd1;
                end else begin
                    owner_d     = OWN_NONE;
                    burst_cnt_d = 4'd0;
                end
            end
        endcase
        if (sel_a) last_d = LAST_A;
        if (sel_b) last_d = LAST_B;
    end

    assign gnt_a = sel_a & reset_n;
    assign gnt_b = sel_b & reset_n;

    assign ram_addr = gnt_b ? addr_b  : addr_a;
    assign ram_wdat = gnt_b ? wdata_b : wdata_a;
    assign ram_wen  = (gnt_a & we_a)  | (gnt_b & we_b);
    assign ram_ren  = (gnt_a & ~we_a) | (gnt_b & ~we_b);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_q     <= OWN_NONE;
            burst_cnt_q <= 4'd0;
            last_q      <= LAST_B;
            rd_pend_a_q <= 1'b0;
            rd_pend_b_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
            rd_pend_a_q <= gnt_a & ~we_a;
            rd_pend_b_q <= gnt_b & ~we_b;
        end
    end

    assign rvalid_a = rd_pend_a_q;
    assign rvalid_b = rd_pend_b_q;
    assign rdata_a  = ram_rdat;
    assign rdata_b  = ram_rdat;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with a behavioural 512x32 synchronous RAM behind it.
// Driver checks grants and RAM commands; a monitor pops expected read returns from a queue.
module tb_ram_arbiter;

    logic        clock;
    logic        reset_n;
    logic        req_a, req_b, we_a, we_b;
    logic [8:0]  addr_a, addr_b;
    logic [31:0] wdata_a, wdata_b;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [31:0] rdata_a, rdata_b;
    logic [8:0]  ram_addr;
    logic        ram_wen, ram_ren;
    logic [31:0] ram_wdat, ram_rdat;

    ram_arbiter #(.ADDR_W(9), .DATA_W(32), .BURST_LEN(4)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req_a    (req_a),
        .req_b    (req_b),
        .we_a     (we_a),
        .we_b     (we_b),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .wdata_a  (wdata_a),
        .wdata_b  (wdata_b),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .rvalid_a (rvalid_a),
        .rvalid_b (rvalid_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .ram_addr (ram_addr),
        .ram_wen  (ram_wen),
        .ram_wdat (ram_wdat),
        .ram_ren  (ram_ren),
        .ram_rdat (ram_rdat)
    );

    logic [31:0] mem [0:511];
    always @(posedge clock) begin
        if (ram_wen) mem[ram_addr] <= ram_wdat;
        if (ram_ren) ram_rdat <= mem[ram_addr];
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic        side;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        chk("wen_ren_exclusive", 32'(ram_wen & ram_ren), 32'd0);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            if (exp_q[0].side == 1'b0) begin
                chk("rvalid_a", 32'(rvalid_a), 32'd1);
                chk("rvalid_b_quiet", 32'(rvalid_b), 32'd0);
                chk("rdata_a", rdata_a, exp_q[0].data);
            end else begin
                chk("rvalid_b", 32'(rvalid_b), 32'd1);
                chk("rvalid_a_quiet", 32'(rvalid_a), 32'd0);
                chk("rdata_b", rdata_b, exp_q[0].data);
            end
            void'(exp_q.pop_front());
        end else begin
            chk("rvalid_a_idle", 32'(rvalid_a), 32'd0);
            chk("rvalid_b_idle", 32'(rvalid_b), 32'd0);
        end
    end

    // Called just after a rising edge; occupies exactly one cycle.
    task automatic step(input logic ra, input logic wa, input logic [8:0] aa, input logic [31:0] da,
                        input logic rb, input logic wb, input logic [8:0] ab, input logic [31:0] db,
                        input logic ega, input logic egb, input logic [31:0] erd);
        exp_t e;
        req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
        @(negedge clock);
        chk("gnt_a", 32'(gnt_a), 32'(ega));
        chk("gnt_b", 32'(gnt_b), 32'(egb));
        if (ega || egb) begin
            chk("ram_addr", 32'(ram_addr), ega ? 32'(aa) : 32'(ab));
            chk("ram_wen", 32'(ram_wen), ega ? 32'(wa) : 32'(wb));
            chk("ram_ren", 32'(ram_ren), ega ? 32'(!wa) : 32'(!wb));
            if (ega ? wa : wb) begin
                chk("ram_wdat", ram_wdat, ega ? da : db);
            end else begin
                e.side = egb;
                e.data = erd;
                e.due  = cyc + 1;
                exp_q.push_back(e);
            end
        end else begin
            chk("ram_cmd_idle", 32'(ram_wen | ram_ren), 32'd0);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0;
        #1;
        chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rst_rvalid_b", 32'(rvalid_b), 32'd0);
        @(negedge clock);
        chk("rst_gnt_a", 32'(gnt_a), 32'd0);
        chk("rst_gnt_b", 32'(gnt_b), 32'd0);
        chk("rst_ram_cmd", 32'(ram_wen | ram_ren), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1;
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
        #1;
        do_reset();

        // A writes then reads address 5
        step(1'b1, 1'b1, 9'd5, 32'hDEADBEEF, 1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 9'd5, 32'd0,        1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF);
        idle();

        // Two ties from idle after reset: A, then B
        do_reset();
        step(1'b1, 1'b0, 9'd5, 32'd0, 1'b1, 1'b0, 9'd5, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF);
        idle();
        step(1'b1, 1'b0, 9'd5, 32'd0, 1'b1, 1'b0, 9'd5, 32'd0, 1'b0, 1'b1, 32'hDEADBEEF);
        idle();

        // Both hold reads: A x4, B x4, A x4
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 9'd5, 32'd0, 1'b1, 1'b0, 9'd5, 32'd0,
                 (i < 4 || i >= 8), (i >= 4 && i < 8), 32'hDEADBEEF);
        end
        idle();

        // B writes top address, A reads it back next cycle
        step(1'b0, 1'b0, 9'd0,   32'd0, 1'b1, 1'b1, 9'd511, 32'h1234, 1'b0, 1'b1, 32'd0);
        step(1'b1, 1'b0, 9'd511, 32'd0, 1'b0, 1'b0, 9'd0,   32'd0,    1'b1, 1'b0, 32'h1234);
        idle();

        // A alone for 10 cycles, no gaps across burst boundaries
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 9'd511, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 32'h1234);
        end
        idle();

        // Reset while a read return is in flight
        step(1'b1, 1'b0, 9'd5, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF);
        chk("rvalid_before_reset", 32'(rvalid_a), 32'd1);
        do_reset();
        step(1'b1, 1'b0, 9'd5, 32'd0, 1'b1, 1'b0, 9'd5, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF);
        idle();
        idle();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares the single-port 512x32 synchronous `ram` between two masters, A and B. It accepts at most one access per cycle, with round-robin fairness and bounded burst ownership. The arbiter drives the RAM command signals and returns registered read data to the requester that issued the read. It sits directly in front of `ram`; both masters connect only to this block, never to the RAM.

## Interface
Parameters:
- `ADDR_W`, 9, RAM address width (512 words)
- `DATA_W`, 32, data width
- `BURST_LEN`, 4, max consecutive grants to one owner while the other requests (range 1..15)

Ports:
- `clock`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  reset, asynchronous and active-low
- `req_a`, `req_b`  in  1  access request, held until granted
- `we_a`, `we_b`  in  1  1 = write, 0 = read; qualified by req
- `addr_a`, `addr_b`  in  ADDR_W  access address
- `wdata_a`, `wdata_b`  in  DATA_W  write data
- `gnt_a`, `gnt_b`  out  1  combinational; access accepted this cycle
- `rvalid_a`, `rvalid_b`  out  1  registered; rdata valid this cycle
- `rdata_a`, `rdata_b`  out  DATA_W  read data, both driven from `ram_rdat`
- `ram_addr`  out  ADDR_W  to RAM `addr`
- `ram_wen`  out  1  to RAM `wEn`
- `ram_wdat`  out  DATA_W  to RAM `wDat`
- `ram_ren`  out  1  to RAM `rEn`
- `ram_rdat`  in  DATA_W  from RAM `rDat`

## Operation
- State registers:
  - `owner`: NONE / A / B
  - `burst_cnt`: 0..BURST_LEN
  - `last`: A / B, the last granted requester
  - `rd_pend_a`, `rd_pend_b`: read-return pipeline bits
- Reset values: owner = NONE, burst_cnt = 0, last = B (so A wins the first tie), rd_pend = 0, rvalid_a/b = 0. gnt_a/b = 0 while reset_n is low.
- Grant selection, evaluated each cycle and producing at most one grant:
  - If owner = X, req_X = 1 and burst_cnt < BURST_LEN: grant X, burst_cnt += 1.
  - Else if the other requester Y has req_Y = 1: grant Y, owner ← Y, burst_cnt ← 1.
  - Else if owner X still requests (burst expired, Y idle): grant X, burst_cnt ← 1.
  - Else if owner = NONE or owner has dropped req:
    - Exactly one requester: grant it.
    - Both requesting: grant the one ≠ last.
    - In either case owner ← winner, burst_cnt ← 1.
  - No requests: owner ← NONE, burst_cnt ← 0; last is retained.
- last ← the granted requester on every grant.
- RAM command for the granted requester X, same cycle as the grant:
  - ram_addr = addr_X.
  - ram_wdat = wdata_X.
  - ram_wen = we_X.
  - ram_ren = ~we_X.
- RAM command with no grant: ram_wen = ram_ren = 0. ram_addr and ram_wdat are don't-care; drive them from A.
- ram_wen and ram_ren are never both 1.
- Read return: on a granted read by X, rd_pend_X ← 1 at the edge. rvalid_X = rd_pend_X, so it is high for exactly the one cycle after the grant, with rdata_X = ram_rdat.
- A granted write produces no rvalid.
- Reads are single-cycle accesses. Back-to-back reads give back-to-back rvalid pulses.

## Timing
- Grant latency: 0 cycles when uncontended; requests are combinationally granted in the cycle they are presented.
- Read latency: 1 cycle from grant to rvalid/rdata.
- Throughput: 1 access per cycle in aggregate.
- Worst-case wait for a requester while the other holds its request: BURST_LEN cycles.
- Read-after-write to the same address in consecutive grants returns the new data, because the write commits at the grant edge.
- Asynchronous reset mid-operation: rvalid drops immediately and a pending read's data is discarded. An in-flight RAM write on the reset edge is not guaranteed.
- A requester that drops req while it is owner loses ownership the same cycle; the other requester may be granted that cycle.

## Test plan
- Reset, then A writes 0xDEADBEEF to address 5, then A reads address 5 → gnt_a on both cycles; rvalid_a high one cycle after the read grant with rdata_a = 0xDEADBEEF; rvalid_b stays 0.
- req_a and req_b rise together from idle with single-cycle requests, repeated twice → first tie grants A, second tie grants B; never both gnt in a cycle.
- A and B both hold reads continuously with BURST_LEN = 4 → grant pattern A×4, B×4, A×4; each rvalid_X pulse follows its gnt_X by exactly 1 cycle.
- B writes 0x1234 to address 511, then A reads address 511 in the next cycle → rdata_a = 0x1234; ram_wen and ram_ren never high together.
- Only A requests for 10 cycles → gnt_a on all 10 cycles; burst_cnt wraps to 1 after reaching 4; no gaps.
- reset_n pulled low in the cycle after a read grant → rvalid goes to 0 asynchronously; after release, owner = NONE and the next tie grants A.
